// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_buf
// Brief   : Pipeline stage register with valid/ready, flush, stall, skid buffer
// Revision: 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int                  DATA_W      = 32,
    parameter int                  CTRL_W      = 24,
    parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = '0,
    parameter int                  SKID        = 1,
    parameter int                  CLEAR_DATA  = 1,
    parameter int                  CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic [1:0]        OCC,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    localparam logic [CNT_W:0] c_CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_data;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_pop;
    logic [1:0]        w_discard;
    logic [CNT_W:0]    w_cnt_sum;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_pop    = r_m_valid & OUT_READY;
    assign w_accept = IN_VALID & w_in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_s_valid;
            logic [DATA_W-1:0] r_s_data;
            logic [CTRL_W-1:0] r_s_ctrl;

            // Ready comes only from flops: the skid slot absorbs the one entry
            // accepted while a downstream stall is still propagating.
            assign w_in_ready = ~r_s_valid & ~STALL & ~FLUSH;
            assign w_s_valid  = r_s_valid;
            assign w_s_data   = r_s_data;
            assign w_s_ctrl   = r_s_ctrl;

            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    r_s_valid <= 1'b0;
                    r_s_data  <= '0;
                    r_s_ctrl  <= BUBBLE_CTRL;
                end else if (FLUSH) begin
                    r_s_valid <= 1'b0;
                    r_s_ctrl  <= BUBBLE_CTRL;
                    if (CLEAR_DATA != 0) begin
                        r_s_data <= '0;
                    end
                end else if (w_accept && r_m_valid && !w_pop) begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= IN_DATA;
                    r_s_ctrl  <= IN_CTRL;
                end else if (w_pop) begin
                    r_s_valid <= 1'b0;
                end
            end
        end else begin : g_noskid
            assign w_in_ready = ~STALL & ~FLUSH & (~r_m_valid | OUT_READY);
            assign w_s_valid  = 1'b0;
            assign w_s_data   = '0;
            assign w_s_ctrl   = BUBBLE_CTRL;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ctrl  <= BUBBLE_CTRL;
        end else if (FLUSH) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= BUBBLE_CTRL;
            if (CLEAR_DATA != 0) begin
                r_m_data <= '0;
            end
        end else if (w_pop && w_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_s_data;
            r_m_ctrl  <= w_s_ctrl;
        end else if (w_accept && (!r_m_valid || w_pop)) begin
            r_m_valid <= 1'b1;
            r_m_data  <= IN_DATA;
            r_m_ctrl  <= IN_CTRL;
        end else if (w_pop) begin
            r_m_valid <= 1'b0;
        end
    end

    // An entry popped in the flush cycle was consumed, so it is not counted.
    assign w_discard = {1'b0, r_m_valid & ~w_pop} + {1'b0, w_s_valid};
    assign w_cnt_sum = {1'b0, r_flush_cnt} + {{(CNT_W-1){1'b0}}, w_discard};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_flush_cnt <= '0;
        end else if (FLUSH) begin
            if (w_cnt_sum > c_CNT_MAX) begin
                r_flush_cnt <= {CNT_W{1'b1}};
            end else begin
                r_flush_cnt <= w_cnt_sum[CNT_W-1:0];
            end
        end
    end

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = r_m_valid;
    assign OUT_DATA  = r_m_data;
    assign OUT_CTRL  = r_m_valid ? r_m_ctrl : BUBBLE_CTRL;
    assign OCC       = {1'b0, r_m_valid} + {1'b0, w_s_valid};
    assign FLUSH_CNT = r_flush_cnt;

endmodule
`default_nettype wire
